// File: rtl/cnn_fm_checker.sv
// cnn_fm_checker: compares a DUT feature-map stream against a golden stream
// element by element, within an absolute tolerance, in raster order
// (c fastest, then r, then m).
// Reports pass/fail, a saturating mismatch count and the first mismatching
// coordinate.
// Optional feature macro: CHECK_TIMEOUT_EN adds a stall watchdog that aborts
// a pass after TIMEOUT_p consecutive RUN cycles without a beat.

module cnn_fm_checker #(
  parameter int M_p       = 1,
  parameter int R_p       = 4,
  parameter int C_p       = 4,
  parameter int W_p       = 16,
  parameter int TOL_p     = 2,
  parameter int TIMEOUT_p = 1024
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic                                       start_i,
  input  logic [W_p-1:0]                             dut_data_i,
  input  logic                                       dut_valid_i,
  output logic                                       dut_ready_o,
  input  logic [W_p-1:0]                             gold_data_i,
  input  logic                                       gold_valid_i,
  output logic                                       gold_ready_o,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       pass_o,
  output logic [$clog2(M_p*R_p*C_p+1)-1:0]           err_count_o,
  output logic                                       first_err_valid_o,
  output logic [((M_p > 1) ? $clog2(M_p) : 1)-1:0]   first_err_m_o,
  output logic [((R_p > 1) ? $clog2(R_p) : 1)-1:0]   first_err_r_o,
  output logic [((C_p > 1) ? $clog2(C_p) : 1)-1:0]   first_err_c_o,
  output logic                                       timeout_o
);

  localparam int TOTAL_C = M_p * R_p * C_p;
  localparam int CNT_W   = $clog2(TOTAL_C + 1);
  localparam int MW      = (M_p > 1) ? $clog2(M_p) : 1;
  localparam int RW      = (R_p > 1) ? $clog2(R_p) : 1;
  localparam int CW      = (C_p > 1) ? $clog2(C_p) : 1;

  localparam logic [CNT_W-1:0] TOTAL_V = CNT_W'(TOTAL_C);
  localparam logic [MW-1:0]    M_LAST  = MW'(M_p - 1);
  localparam logic [RW-1:0]    R_LAST  = RW'(R_p - 1);
  localparam logic [CW-1:0]    C_LAST  = CW'(C_p - 1);
  localparam logic [W_p:0]     TOL_V   = (W_p + 1)'(TOL_p);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [MW-1:0]    m_q;
  logic [RW-1:0]    r_q;
  logic [CW-1:0]    c_q;
  logic [CNT_W-1:0] err_count_q;
  logic             first_err_valid_q;
  logic [MW-1:0]    first_m_q;
  logic [RW-1:0]    first_r_q;
  logic [CW-1:0]    first_c_q;

  logic             in_run;
  logic             beat;
  logic             last_elem;
  logic             start_pass;
  logic             stall_hit;
  logic             mismatch;
  logic [W_p:0]     diff;
  logic [W_p:0]     abs_diff;

  assign in_run     = (state_q == RUN);
  assign beat       = in_run && dut_valid_i && gold_valid_i;
  assign last_elem  = (m_q == M_LAST) && (r_q == R_LAST) && (c_q == C_LAST);
  assign start_pass = start_i && (state_q != RUN);

  // Widen both operands by one sign bit so the difference can never overflow,
  // then take its magnitude and compare against the tolerance.
  always_comb begin
    diff     = {dut_data_i[W_p-1], dut_data_i} - {gold_data_i[W_p-1], gold_data_i};
    abs_diff = diff;
    if (diff[W_p]) begin
      abs_diff = ~diff + 1'b1;
    end
    mismatch = (abs_diff > TOL_V);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start launches a pass from IDLE or DONE; the final beat
  // or a watchdog abort finishes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (beat && last_elem) begin
          state_d = DONE;
        end else if (stall_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster counters, saturating error count and first-mismatch capture.
  always_ff @(posedge clk_i) begin
    if (reset_i || start_pass) begin
      m_q               <= '0;
      r_q               <= '0;
      c_q               <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_m_q         <= '0;
      first_r_q         <= '0;
      first_c_q         <= '0;
    end else if (beat) begin
      if (c_q == C_LAST) begin
        c_q <= '0;
        if (r_q == R_LAST) begin
          r_q <= '0;
          if (m_q == M_LAST) begin
            m_q <= '0;
          end else begin
            m_q <= m_q + 1'b1;
          end
        end else begin
          r_q <= r_q + 1'b1;
        end
      end else begin
        c_q <= c_q + 1'b1;
      end
      if (mismatch) begin
        if (err_count_q != TOTAL_V) begin
          err_count_q <= err_count_q + 1'b1;
        end
        if (!first_err_valid_q) begin
          first_err_valid_q <= 1'b1;
          first_m_q         <= m_q;
          first_r_q         <= r_q;
          first_c_q         <= c_q;
        end
      end
    end
  end

`ifdef CHECK_TIMEOUT_EN
  localparam int                STALL_W    = $clog2(TIMEOUT_p + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_p - 1);

  logic [STALL_W-1:0] stall_q;
  logic               timeout_q;

  assign stall_hit = in_run && !beat && (stall_q == STALL_LAST);
  assign timeout_o = timeout_q;

  // Stall watchdog: counts consecutive beat-less RUN cycles and flags an
  // abort on the cycle the count would reach the limit.
  always_ff @(posedge clk_i) begin
    if (reset_i || start_pass) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else if (in_run) begin
      if (beat) begin
        stall_q <= '0;
      end else begin
        stall_q <= stall_q + 1'b1;
      end
      if (stall_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_param;

  assign unused_timeout_param = (TIMEOUT_p != 0);
  assign stall_hit            = 1'b0;
  assign timeout_o            = 1'b0;
`endif

  assign dut_ready_o       = in_run && gold_valid_i;
  assign gold_ready_o      = in_run && dut_valid_i;
  assign busy_o            = in_run;
  assign done_o            = (state_q == DONE);
  assign pass_o            = done_o && (err_count_q == '0) && !timeout_o;
  assign err_count_o       = err_count_q;
  assign first_err_valid_o = first_err_valid_q;
  assign first_err_m_o     = first_m_q;
  assign first_err_r_o     = first_r_q;
  assign first_err_c_o     = first_c_q;

endmodule

// File: tb/tb_cnn_fm_checker.sv
// Directed testbench for cnn_fm_checker: a default 1x4x4 instance, a 2x2x3
// instance for channel wrap, and (with CHECK_TIMEOUT_EN) a watchdog instance.

module tb_cnn_fm_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Default-geometry instance
  logic        start_a = 1'b0, dv_a = 1'b0, gv_a = 1'b0;
  logic [15:0] dd_a = '0, gd_a = '0;
  logic        dr_a, gr_a, busy_a, done_a, pass_a, fev_a, to_a;
  logic [4:0]  err_a;
  logic [0:0]  fm_a;
  logic [1:0]  fr_a, fc_a;
  logic [15:0] dut_vec[16];
  logic [15:0] gold_vec[16];

  cnn_fm_checker u_a (
    .clk_i(clk), .reset_i(reset), .start_i(start_a),
    .dut_data_i(dd_a), .dut_valid_i(dv_a), .dut_ready_o(dr_a),
    .gold_data_i(gd_a), .gold_valid_i(gv_a), .gold_ready_o(gr_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_count_o(err_a),
    .first_err_valid_o(fev_a), .first_err_m_o(fm_a), .first_err_r_o(fr_a),
    .first_err_c_o(fc_a), .timeout_o(to_a)
  );

  // 2x2x3 instance
  logic        start_b = 1'b0, dv_b = 1'b0, gv_b = 1'b0;
  logic [15:0] dd_b = '0, gd_b = '0;
  logic        dr_b, gr_b, busy_b, done_b, pass_b, fev_b, to_b;
  logic [3:0]  err_b;
  logic [0:0]  fm_b, fr_b;
  logic [1:0]  fc_b;

  cnn_fm_checker #(.M_p(2), .R_p(2), .C_p(3)) u_b (
    .clk_i(clk), .reset_i(reset), .start_i(start_b),
    .dut_data_i(dd_b), .dut_valid_i(dv_b), .dut_ready_o(dr_b),
    .gold_data_i(gd_b), .gold_valid_i(gv_b), .gold_ready_o(gr_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_count_o(err_b),
    .first_err_valid_o(fev_b), .first_err_m_o(fm_b), .first_err_r_o(fr_b),
    .first_err_c_o(fc_b), .timeout_o(to_b)
  );

`ifdef CHECK_TIMEOUT_EN
  // Watchdog instance with a short stall limit
  logic        start_c = 1'b0, dv_c = 1'b0, gv_c = 1'b0;
  logic [15:0] dd_c = '0, gd_c = '0;
  logic        dr_c, gr_c, busy_c, done_c, pass_c, fev_c, to_c;
  logic [4:0]  err_c;
  logic [0:0]  fm_c;
  logic [1:0]  fr_c, fc_c;

  cnn_fm_checker #(.TIMEOUT_p(8)) u_c (
    .clk_i(clk), .reset_i(reset), .start_i(start_c),
    .dut_data_i(dd_c), .dut_valid_i(dv_c), .dut_ready_o(dr_c),
    .gold_data_i(gd_c), .gold_valid_i(gv_c), .gold_ready_o(gr_c),
    .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c), .err_count_o(err_c),
    .first_err_valid_o(fev_c), .first_err_m_o(fm_c), .first_err_r_o(fr_c),
    .first_err_c_o(fc_c), .timeout_o(to_c)
  );
`endif

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Starts a pass on instance A and feeds nbeats elements from the vectors.
  // mode 0: both valid every cycle; mode 1: gold valid toggles, dut valid random.
  // Returns with inputs idle, 1 time unit after the edge of the last beat.
  task automatic applyStimulus(input int mode, input int nbeats, output int cycles);
    int idx = 0;
    int guard = 0;
    int join_viol = 0;
    int early_done = 0;
    cycles = 0;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    while (idx < nbeats && guard < 300) begin
      if (mode == 0) begin
        dv_a = 1'b1;
        gv_a = 1'b1;
      end else begin
        gv_a = (guard % 2 == 0);
        dv_a = 1'($urandom_range(0, 1));
      end
      dd_a = dut_vec[idx];
      gd_a = gold_vec[idx];
      #1;
      if ((dr_a && !gv_a) || (gr_a && !dv_a)) join_viol++;
      if (done_a) early_done++;
      @(posedge clk);
      if (dv_a && gv_a) idx++;
      #1;
      guard++;
      cycles++;
    end
    dv_a = 1'b0;
    gv_a = 1'b0;
    checkOutput("beats_consumed", idx, nbeats);
    checkOutput("ready_join", join_viol, 0);
    checkOutput("no_early_done", early_done, 0);
  endtask

  initial begin
    int cyc;
    int n;

    // Reset with valids high: everything must read 0, including readies.
    dv_a = 1'b1;
    gv_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {busy_a, done_a, pass_a, fev_a, to_a, dr_a, gr_a}, 0);
    checkOutput("reset_err", err_a, 0);
    dv_a = 1'b0;
    gv_a = 1'b0;
    reset = 1'b0;

    // Matching ramp 0..15
    $display("[TB] matching ramp");
    for (int i = 0; i < 16; i++) begin
      dut_vec[i]  = 16'(i);
      gold_vec[i] = 16'(i);
    end
    applyStimulus(0, 16, cyc);
    checkOutput("ramp_cycles", cyc, 16);
    checkOutput("ramp_done", done_a, 1);
    checkOutput("ramp_pass", pass_a, 1);
    checkOutput("ramp_err", err_a, 0);
    checkOutput("ramp_fev", fev_a, 0);
    checkOutput("ramp_busy", busy_a, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_holds", {done_a, pass_a}, 2'b11);

    // Tolerance: 102 accepted, 97 rejected
    $display("[TB] tolerance edges");
    for (int i = 0; i < 16; i++) begin
      dut_vec[i]  = 16'd100;
      gold_vec[i] = 16'd100;
    end
    dut_vec[6]  = 16'd102;
    dut_vec[12] = 16'd97;
    applyStimulus(0, 16, cyc);
    checkOutput("tol_err", err_a, 1);
    checkOutput("tol_first", {fev_a, fm_a, fr_a, fc_a}, {1'b1, 1'b0, 2'd3, 2'd0});
    checkOutput("tol_pass", {done_a, pass_a}, 2'b10);

    // Extreme values: differences that would overflow W_p bits
    $display("[TB] extreme differences");
    for (int i = 0; i < 16; i++) begin
      dut_vec[i]  = 16'h0000;
      gold_vec[i] = 16'h0000;
    end
    dut_vec[0]  = 16'h7fff; gold_vec[0]  = 16'h8000;
    dut_vec[5]  = 16'h8000; gold_vec[5]  = 16'h7fff;
    dut_vec[9]  = 16'hfffe;
    dut_vec[10] = 16'h0001; gold_vec[10] = 16'hffff;
    dut_vec[11] = 16'hffff; gold_vec[11] = 16'h0002;
    applyStimulus(0, 16, cyc);
    checkOutput("ext_err", err_a, 3);
    checkOutput("ext_first", {fev_a, fm_a, fr_a, fc_a}, {1'b1, 1'b0, 2'd0, 2'd0});
    checkOutput("ext_pass", pass_a, 0);

    // Irregular valids, most-negative data
    $display("[TB] irregular handshake");
    for (int i = 0; i < 16; i++) begin
      dut_vec[i]  = 16'h8000;
      gold_vec[i] = 16'h8000;
    end
    applyStimulus(1, 16, cyc);
    checkOutput("irr_done", done_a, 1);
    checkOutput("irr_pass", pass_a, 1);

    // Reset mid-pass, then a clean pass from (0,0,0)
    $display("[TB] reset mid-pass");
    for (int i = 0; i < 16; i++) begin
      dut_vec[i]  = 16'(i * 3);
      gold_vec[i] = 16'(i * 3);
    end
    dut_vec[2] = 16'd50;
    applyStimulus(0, 7, cyc);
    checkOutput("pre_reset_err", err_a, 1);
    dv_a = 1'b1;
    gv_a = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_outputs", {busy_a, done_a, pass_a, fev_a, to_a, dr_a, gr_a}, 0);
    checkOutput("midreset_err", err_a, 0);
    reset = 1'b0;
    dv_a = 1'b0;
    gv_a = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_no_done", {busy_a, done_a}, 0);
    dut_vec[2] = 16'd6;
    applyStimulus(0, 16, cyc);
    checkOutput("after_reset_cycles", cyc, 16);
    checkOutput("after_reset_pass", {done_a, pass_a, err_a}, {1'b1, 1'b1, 5'd0});

    // Long stall and start during RUN: pass resumes where it stopped
    $display("[TB] stall and ignored start");
    applyStimulus(0, 2, cyc);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("stall_waits", {busy_a, done_a, to_a}, 3'b100);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int k = 2; k < 16; k++) begin
      dv_a = 1'b1;
      gv_a = 1'b1;
      dd_a = dut_vec[k];
      gd_a = gold_vec[k];
      @(posedge clk); #1;
    end
    dv_a = 1'b0;
    gv_a = 1'b0;
    checkOutput("start_ignored_done", {done_a, pass_a}, 2'b11);

    // 2x2x3 geometry, mismatches at beats 4 and 9
    $display("[TB] channel wrap");
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 0; k < 12; k++) begin
      dv_b = 1'b1;
      gv_b = 1'b1;
      gd_b = 16'd0;
      dd_b = (k == 4 || k == 9) ? 16'd5 : 16'd0;
      @(posedge clk); #1;
      if (k == 3) checkOutput("wrap_err_before", err_b, 0);
      if (k == 4) checkOutput("wrap_err_latency", {fev_b, err_b}, {1'b1, 4'd1});
      if (k == 10) checkOutput("wrap_not_done", done_b, 0);
    end
    dv_b = 1'b0;
    gv_b = 1'b0;
    checkOutput("wrap_err", err_b, 2);
    checkOutput("wrap_first", {fm_b, fr_b, fc_b}, {1'b0, 1'b1, 2'd1});
    checkOutput("wrap_done", {done_b, pass_b, to_b}, 3'b100);

`ifdef CHECK_TIMEOUT_EN
    // Watchdog: 3 beats then a permanent DUT stall
    $display("[TB] watchdog");
    @(posedge clk); #1;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    dv_c = 1'b1;
    gv_c = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    dv_c = 1'b0;
    n = 0;
    while (!done_c && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    gv_c = 1'b0;
    checkOutput("wd_cycles", n, 8);
    checkOutput("wd_flags", {done_c, to_c, pass_c, err_c}, {1'b1, 1'b1, 1'b0, 5'd0});
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    checkOutput("wd_restart", {busy_c, to_c, done_c}, 3'b100);
`else
    n = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_fm_checker.md
Name: cnn_fm_checker

Overview:
- Hardware self-checking comparator for CNN output feature maps.
- Consumes two element streams in raster order: the DUT output fm and the golden fm read from memory. It compares them element by element within a configurable absolute tolerance.
- Reports pass/fail, a mismatch count and the first mismatching coordinate.
- Sits between the cnn core output, the golden-data mem port and the test/status logic. It replaces end-of-run single-element spot checks with a full-map, cycle-accurate check.

Parameters:
- M_p, 1, output channel count
- R_p, 4, output rows
- C_p, 4, output columns
- W_p, 16, element width (signed two's-complement fixed point)
- TOL_p, 2, max allowed |dut - gold| in LSBs (0 = exact match)
- TIMEOUT_p, 1024, stall limit in cycles (used only with CHECK_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  begin a check pass (pulse)
- dut_data_i  in  W_p  DUT output element
- dut_valid_i  in  1  DUT element valid
- dut_ready_o  out  1  checker accepts DUT element
- gold_data_i  in  W_p  golden element
- gold_valid_i  in  1  golden element valid
- gold_ready_o  out  1  checker accepts golden element
- busy_o  out  1  check in progress
- done_o  out  1  check complete (level)
- pass_o  out  1  all elements within tolerance (valid when done_o)
- err_count_o  out  $clog2(M_p*R_p*C_p+1)  number of mismatches
- first_err_valid_o  out  1  at least one mismatch captured
- first_err_m_o / first_err_r_o / first_err_c_o  out  $clog2 of M_p / R_p / C_p (min 1)  coordinate of first mismatch
- timeout_o  out  1  pass aborted by watchdog

Behaviour:
- Reset (synchronous, active-high) forces state IDLE. All outputs 0, counters m/r/c = 0, err_count = 0. Reset mid-RUN aborts the pass with no done_o.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i. Counters, err_count and first_err_* clear on that edge.
  - RUN -> DONE on the beat consuming element (M_p-1, R_p-1, C_p-1).
  - DONE -> RUN on start_i, with the same clears. Otherwise DONE holds.
  - start_i while in RUN is ignored.
- Ready outputs form a join handshake:
  - dut_ready_o = RUN & gold_valid_i; gold_ready_o = RUN & dut_valid_i.
  - A beat occurs when dut_valid_i & gold_valid_i in RUN. Both streams advance together; there is never a one-sided consume.
  - Both ready outputs are 0 in IDLE/DONE.
- Compare: diff = sign-extended (W_p+1)-bit dut - gold; the element is a mismatch when |diff| > TOL_p. Most-negative diff is handled by the extra bit; no overflow.
- Results are registered: err_count_o and first_err_* update on the clock edge of the beat, so there is 1-cycle latency from beat to visible count.
- first_err_* latch only on the first mismatch of a pass and are held afterwards.
- Index order: c fastest, then r, then m. Each counter wraps to 0 at C_p-1 / R_p-1 and carries into the next.
- err_count_o saturates at M_p*R_p*C_p (it cannot exceed this in practice; saturation is required anyway).
- busy_o = (state == RUN). done_o = (state == DONE).
- pass_o = done_o & (err_count == 0) & ~timeout_o.
- done_o and pass_o assert on the cycle after the final beat and hold until start_i or reset_i.
- Degenerate M_p=R_p=C_p=1: a single beat moves RUN -> DONE.

Optional Feature:
- CHECK_TIMEOUT_EN defined:
  - A stall counter increments each RUN cycle with no beat and clears on a beat or on entry to RUN.
  - When it reaches TIMEOUT_p, the block goes to DONE with timeout_o=1 and pass_o=0.
  - err_count_o and first_err_* hold their values at abort.
  - timeout_o clears on start_i or reset_i.
- CHECK_TIMEOUT_EN undefined: no stall counter; timeout_o is tied 0; RUN waits indefinitely.

Test Plan:
- Defaults; 16 matching elements 0..15 on both streams, both valid every cycle -> 16 beats. done_o=1 on cycle 17 after start. pass_o=1, err_count_o=0, first_err_valid_o=0.
- Gold=100 everywhere; dut=102 at (0,1,2) and dut=97 at (0,3,0), all else 100 -> 102 is within TOL and accepted; 97 is a mismatch. Expect err_count_o=1, first_err=(0,3,0), pass_o=0.
- gold_valid_i toggling 1-0 and dut_valid_i random, gold=dut=-32768 -> no one-sided consume. done_o after exactly 16 beats, pass_o=1. dut_ready_o is never 1 while gold_valid_i=0.
- M_p=2, R_p=2, C_p=3; mismatches at raster beats 4 and 9 -> first_err=(0,1,1), err_count_o=2. The counter wraps correctly across the channel boundary.
- reset_i asserted after 7 beats, then start_i with matching data -> all outputs 0 during reset. The new pass checks all 16 elements from (0,0,0) and reports pass_o=1.
- With CHECK_TIMEOUT_EN and TIMEOUT_p=8: start, 3 beats, then dut_valid_i=0 -> timeout_o=1 and done_o=1 exactly 8 cycles after the last beat. pass_o=0. A subsequent start_i clears timeout_o.
